// File: rtl/main_memory_wb_buffer_512x16.sv
// Main-memory stage behind the L1 caches: a FIFO write-back buffer draining into a
// 512x16 array, and a fixed-latency line-fill read port that forwards from pending write-backs.
module main_memory_wb_buffer_512x16 #(
  parameter int WB_DEPTH     = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [8:0]  wb_address,
  input  logic [15:0] wb_data,
  output logic        wb_ready,
  input  logic        rd_req,
  input  logic [8:0]  rd_address,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        wb_overflow
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [15:0]   mem_q [512];
  logic [8:0]    buf_addr_q [WB_DEPTH];
  logic [15:0]   buf_data_q [WB_DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wb_ready_q, wb_ready_d;
  logic          wb_overflow_q, wb_overflow_d;
  state_t        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_ready_q, rd_ready_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic [15:0]   snap_q, snap_d;

  logic          push, drain, accept, fwd_hit;
  logic [15:0]   fwd_data, snap_src;
  logic [PW-1:0] idx;

  always_comb begin
    push          = wb_valid & wb_ready_q;
    drain         = (count_q != '0);
    accept        = rd_req & rd_ready_q;
    head_d        = head_q + PW'(drain);
    tail_d        = tail_q + PW'(push);
    count_d       = count_q + CW'(push) - CW'(drain);
    wb_ready_d    = (count_d < CW'(WB_DEPTH));
    wb_overflow_d = wb_overflow_q | (wb_valid & ~wb_ready_q);

    // Oldest-to-youngest scan so the youngest match wins; the head entry draining
    // this cycle is still within count_q and therefore still forwardable.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (buf_addr_q[idx] == rd_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data_q[idx];
      end
    end

    if (push && (wb_address == rd_address)) snap_src = wb_data;
    else if (fwd_hit)                       snap_src = fwd_data;
    else                                    snap_src = mem_q[rd_address];

    state_d    = state_q;
    lat_d      = lat_q;
    snap_d     = snap_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          snap_d  = snap_src;
          lat_d   = LW'(READ_LATENCY - 1);
          state_d = (READ_LATENCY == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q <= LW'(1)) state_d = S_DONE;
        else                 lat_d   = lat_q - LW'(1);
      end
      S_DONE: begin
        state_d    = S_IDLE;
        rd_valid_d = 1'b1;
        rd_data_d  = snap_q;
      end
      default: state_d = S_IDLE;
    endcase
    // Ready stays low through the rd_valid cycle so reads cannot overlap.
    rd_ready_d = (state_d == S_IDLE) && !rd_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      wb_ready_q    <= 1'b1;
      wb_overflow_q <= 1'b0;
      state_q       <= S_IDLE;
      lat_q         <= '0;
      rd_valid_q    <= 1'b0;
      rd_ready_q    <= 1'b1;
      rd_data_q     <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      wb_ready_q    <= wb_ready_d;
      wb_overflow_q <= wb_overflow_d;
      state_q       <= state_d;
      lat_q         <= lat_d;
      rd_valid_q    <= rd_valid_d;
      rd_ready_q    <= rd_ready_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Data storage carries no reset; buffer validity lives entirely in count/head/tail.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    if (push) begin
      buf_addr_q[tail_q] <= wb_address;
      buf_data_q[tail_q] <= wb_data;
    end
    if (drain) mem_q[buf_addr_q[head_q]] <= buf_data_q[head_q];
  end

  assign wb_ready    = wb_ready_q;
  assign wb_overflow = wb_overflow_q;
  assign rd_ready    = rd_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_main_memory_wb_buffer_512x16.sv
// Directed bench for main_memory_wb_buffer_512x16: forwarding, array reads, latency,
// busy-read rejection, write-back flow and reset behaviour.
module tb_main_memory_wb_buffer_512x16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [8:0]  wb_address;
  logic [15:0] wb_data;
  logic        wb_ready;
  logic        rd_req;
  logic [8:0]  rd_address;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wb_overflow;

  int errors = 0;
  int checks = 0;

  main_memory_wb_buffer_512x16 #(.WB_DEPTH(4), .READ_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_address(wb_address), .wb_data(wb_data), .wb_ready(wb_ready),
    .rd_req(rd_req), .rd_address(rd_address), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .wb_overflow(wb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wb;
    logic [8:0]  wa;
    logic [15:0] wd;
    int          gap;
    logic [8:0]  ra;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Issues a read (any write-back already set up is applied on the same edge),
  // then checks ready, latency and data.
  task automatic do_read(input string name, input logic [8:0] a, input logic [15:0] e);
    int k;
    rd_req     = 1'b1;
    rd_address = a;
    step();
    rd_req   = 1'b0;
    wb_valid = 1'b0;
    chk({name, " rd_ready_busy"}, 32'(rd_ready), 32'd0);
    k = 0;
    while (!rd_valid && k < 20) begin
      step();
      k++;
    end
    chk({name, " latency"}, 32'(k), 32'd2);
    chk({name, " data"}, 32'(rd_data), 32'(e));
    step();
    chk({name, " rd_ready_after"}, 32'(rd_ready), 32'd1);
    chk({name, " rd_valid_pulse"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic set_wb(input logic [8:0] a, input logic [15:0] d);
    wb_valid   = 1'b1;
    wb_address = a;
    wb_data    = d;
  endtask

  initial begin
    int k;
    int seen;
    vecs[0] = '{1'b1, 9'h123, 16'hBEEF, 1, 9'h123, 16'hBEEF};
    vecs[1] = '{1'b0, 9'h000, 16'h0000, 0, 9'h123, 16'hBEEF};
    vecs[2] = '{1'b1, 9'h040, 16'h1111, 0, 9'h040, 16'h1111};
    vecs[3] = '{1'b1, 9'h0AA, 16'h5555, 2, 9'h0AA, 16'h5555};
    vecs[4] = '{1'b1, 9'h1FE, 16'h1234, 0, 9'h1FD, 16'h0000};
    vecs[5] = '{1'b1, 9'h1FD, 16'h4321, 1, 9'h1FE, 16'h1234};

    rst_n = 1'b0; wb_valid = 1'b0; wb_address = '0; wb_data = '0;
    rd_req = 1'b0; rd_address = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset wb_ready", 32'(wb_ready), 32'd1);
    chk("reset rd_ready", 32'(rd_ready), 32'd1);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    chk("reset wb_overflow", 32'(wb_overflow), 32'd0);

    do_read("read_empty_0A5", 9'h0A5, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_wb) begin
        set_wb(vecs[i].wa, vecs[i].wd);
        if (vecs[i].gap > 0) begin
          step();
          wb_valid = 1'b0;
          for (int g = 1; g < vecs[i].gap; g++) step();
        end
      end
      do_read($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp_d);
    end

    // Back-to-back pushes to one address: the younger value must win.
    set_wb(9'h001, 16'hAAAA); step();
    set_wb(9'h001, 16'hBBBB); step();
    wb_valid = 1'b0;
    do_read("youngest", 9'h001, 16'hBBBB);

    // A write-back after acceptance and a request while busy must not affect the read.
    rd_req = 1'b1; rd_address = 9'h050;
    step();
    rd_address = 9'h123;
    set_wb(9'h050, 16'h7777);
    chk("busy rd_ready", 32'(rd_ready), 32'd0);
    step();
    wb_valid = 1'b0;
    k = 1;
    while (!rd_valid && k < 20) begin
      step();
      k++;
    end
    rd_req = 1'b0;
    chk("busy latency", 32'(k), 32'd2);
    chk("busy data", 32'(rd_data), 32'h0000);
    step();
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (rd_valid) seen++;
      step();
    end
    chk("busy no_extra_valid", 32'(seen), 32'd0);
    do_read("late_wb_visible", 9'h050, 16'h7777);

    // Five consecutive pushes: drain keeps pace, so the buffer never fills.
    for (int p = 0; p < 5; p++) begin
      set_wb(9'h100 + 9'(p), 16'hC000 + 16'(p));
      step();
      chk($sformatf("stream wb_ready%0d", p), 32'(wb_ready), 32'd1);
    end
    wb_valid = 1'b0;
    step();
    chk("stream overflow", 32'(wb_overflow), 32'd0);
    do_read("stream_readback", 9'h102, 16'hC002);

    // Reset one cycle after accepting a read: the read is aborted.
    rd_req = 1'b1; rd_address = 9'h1FF;
    step();
    rd_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("abort rd_ready_in_reset", 32'(rd_ready), 32'd1);
    chk("abort rd_valid_in_reset", 32'(rd_valid), 32'd0);
    step(); step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rd_valid) seen++;
    end
    chk("abort no_rd_valid", 32'(seen), 32'd0);
    chk("abort rd_ready", 32'(rd_ready), 32'd1);
    do_read("array_retained", 9'h123, 16'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
